// File: rtl/fp_serial_pkg.sv
// Shared definitions for the serial FP32 ALU: FSM state encodings, opcode
// encodings and the canonical quiet NaN returned by every NaN-producing path.
package fp_serial_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_addsub.sv
// Combinational FP32 adder/subtractor, round-to-nearest-even, with subnormal
// inputs/outputs. Any NaN input, or inf - inf, yields the canonical qNaN.
//   a, b : operands
//   sub  : 1 computes a - b, 0 computes a + b
//   y    : result
module fp_addsub
    import fp_serial_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] y
);

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (v[i] && !found) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic        b_sign, a_inf, b_inf, swap, same;
    logic [31:0] big, sml;
    logic [7:0]  eb, es, d;
    logic [23:0] mb, ms;
    logic [26:0] xb, xs, xs_sh, rn;
    logic        sticky, rnd;
    logic [27:0] r0, r1;
    logic [9:0]  e0, e1, e2, e3, sh;
    logic [4:0]  lz;
    logic [24:0] mr0, mr1;

    always_comb begin
        b_sign = b[31] ^ sub;
        a_inf  = (a[30:0] == {8'hFF, 23'd0});
        b_inf  = (b[30:0] == {8'hFF, 23'd0});

        // Order by magnitude so the subtraction below never goes negative.
        swap = b[30:0] > a[30:0];
        big  = swap ? {b_sign, b[30:0]} : a;
        sml  = swap ? a : {b_sign, b[30:0]};
        same = (big[31] == sml[31]);

        // Subnormals use exponent 1 with no hidden bit.
        eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        mb = {big[30:23] != 8'd0, big[22:0]};
        ms = {sml[30:23] != 8'd0, sml[22:0]};
        d  = eb - es;

        // Three extra bits: guard, round, sticky. Bits shifted out of the
        // small operand fold into the sticky LSB.
        xb     = {mb, 3'b000};
        xs     = {ms, 3'b000};
        sticky = |(xs & ((27'd1 << d) - 27'd1));
        xs_sh  = (xs >> d) | {26'd0, sticky};

        r0 = same ? ({1'b0, xb} + {1'b0, xs_sh}) : ({1'b0, xb} - {1'b0, xs_sh});
        e0 = {2'b00, eb};

        // Carry out: renormalise right, keeping the sticky information.
        if (r0[27]) begin
            r1 = {1'b0, r0[27:2], r0[1] | r0[0]};
            e1 = e0 + 10'd1;
        end else begin
            r1 = r0;
            e1 = e0;
        end

        // Left normalise, but never below exponent 1 (gradual underflow).
        lz = lzc27(r1[26:0]);
        sh = ({5'd0, lz} < (e1 - 10'd1)) ? {5'd0, lz} : (e1 - 10'd1);
        rn = r1[26:0] << sh;
        e2 = e1 - sh;

        rnd = rn[2] & ((|rn[1:0]) | rn[3]);
        mr0 = {1'b0, rn[26:3]} + {24'd0, rnd};
        if (mr0[24]) begin
            mr1 = {1'b0, mr0[24:1]};
            e3  = e2 + 10'd1;
        end else begin
            mr1 = mr0;
            e3  = e2;
        end

        // A subnormal that rounds up into bit 23 lands on exponent 1 naturally.
        y = {big[31], (mr1[23] ? e3[7:0] : 8'd0), mr1[22:0]};
        if (mr1[23] && (e3 >= 10'd255))
            y = {big[31], 8'hFF, 23'd0};
        // Exact cancellation gives +0; only -0 + -0 keeps the sign.
        if (rn == 27'd0)
            y = {same & big[31], 31'd0};

        if (fp32_is_nan(a) || fp32_is_nan(b) || (a_inf && b_inf && (a[31] != b_sign)))
            y = FP32_QNAN;
        else if (a_inf)
            y = a;
        else if (b_inf)
            y = {b_sign, b[30:0]};
    end

endmodule

// File: rtl/fp_minmax.sv
// Combinational FP32 min/max over a sign-magnitude total order (-0 < +0,
// infinities ordinary). Any NaN operand yields the canonical qNaN; equal
// operands return a.
//   a, b    : operands
//   sel_max : 1 selects max, 0 selects min
//   y       : result
module fp_minmax
    import fp_serial_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel_max,
    output logic [31:0] y
);

    function automatic logic lt(input logic [31:0] x, input logic [31:0] z);
        if (x[31] != z[31])
            return x[31];
        return x[31] ? (x[30:0] > z[30:0]) : (x[30:0] < z[30:0]);
    endfunction

    always_comb begin
        if (fp32_is_nan(a) || fp32_is_nan(b))
            y = FP32_QNAN;
        else if (sel_max)
            y = lt(a, b) ? b : a;
        else
            y = lt(b, a) ? b : a;
    end

endmodule

// File: rtl/fp_serial_alu.sv
// Bus-serial FP32 ALU. Loads A then B as BEATS = 32/BUS_W LSB-first beats,
// holds them for EXEC_LAT cycles while the combinational add/sub/min/max path
// settles, then streams the 32-bit result back out LSB-first.
//   clk, rst              : clock, async active-high reset
//   start, opcode         : request (sampled in IDLE) and operation
//   in_data/valid/ready   : operand beat stream
//   out_data/valid/ready  : result beat stream
//   done                  : one-cycle pulse after the last result beat
//   busy, state_out       : status / debug
module fp_serial_alu
    import fp_serial_pkg::*;
#(
    parameter int BUS_W    = 8,
    parameter int EXEC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output logic             busy,
    output logic [2:0]       state_out
);

    localparam int BEATS = 32 / BUS_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [3:0]     LAST_EXEC = 4'(EXEC_LAT - 1);

    state_t         state;
    logic [1:0]     op;
    logic [31:0]    a_reg, b_reg, res_reg;
    logic [BCW-1:0] beat;
    logic [3:0]     ecnt;
    logic           done_r;
    logic [31:0]    addsub_y, minmax_y, exec_y;
    logic           in_xfer, out_xfer;

    // a_reg/b_reg only change in LOAD states, so this path is a legal
    // EXEC_LAT-cycle multicycle path into res_reg.
    fp_addsub u_addsub (.a(a_reg), .b(b_reg), .sub(op[0]),     .y(addsub_y));
    fp_minmax u_minmax (.a(a_reg), .b(b_reg), .sel_max(op[0]), .y(minmax_y));
    assign exec_y = op[1] ? minmax_y : addsub_y;

    // All outputs decode from registered state; no input-to-output paths.
    assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign out_valid = (state == S_OUTPUT);
    assign out_data  = out_valid ? res_reg[beat*BUS_W +: BUS_W] : '0;
    assign busy      = (state != S_IDLE);
    assign state_out = state;
    assign done      = done_r;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op      <= OP_ADD;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            beat    <= '0;
            ecnt    <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op    <= opcode;
                        beat  <= '0;
                        state <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    if (in_xfer) begin
                        a_reg[beat*BUS_W +: BUS_W] <= in_data;
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= S_LOAD_B;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (in_xfer) begin
                        b_reg[beat*BUS_W +: BUS_W] <= in_data;
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            ecnt  <= '0;
                            state <= S_EXEC;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (ecnt == LAST_EXEC) begin
                        res_reg <= exec_y;
                        beat    <= '0;
                        state   <= S_OUTPUT;
                    end else begin
                        ecnt <= ecnt + 4'd1;
                    end
                end
                S_OUTPUT: begin
                    if (out_xfer) begin
                        if (beat == LAST_BEAT) begin
                            beat   <= '0;
                            done_r <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_serial_alu.sv
// Bench for fp_serial_alu: an 8-bit/EXEC_LAT=1 instance runs a vector table,
// back-pressure, input gaps and mid-load reset; a 32-bit/EXEC_LAT=3 instance
// runs held-start back-to-back operations. Result beats are checked against
// a scoreboard queue filled when each operation is issued.
module tb_fp_serial_alu;
    import fp_serial_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       start8, ir8, ov8, ordy8, done8, busy8, iv8;
    logic [1:0] op8;
    logic [7:0] in8, od8;
    logic [2:0] st8;

    // 32-bit instance
    logic        start32, ir32, ov32, ordy32, done32, busy32, iv32;
    logic [1:0]  op32;
    logic [31:0] in32, od32;
    logic [2:0]  st32;

    fp_serial_alu #(.BUS_W(8), .EXEC_LAT(1)) u_d8 (
        .clk(clk), .rst(rst), .start(start8), .opcode(op8),
        .in_data(in8), .in_valid(iv8), .in_ready(ir8),
        .out_data(od8), .out_valid(ov8), .out_ready(ordy8),
        .done(done8), .busy(busy8), .state_out(st8)
    );

    fp_serial_alu #(.BUS_W(32), .EXEC_LAT(3)) u_d32 (
        .clk(clk), .rst(rst), .start(start32), .opcode(op32),
        .in_data(in32), .in_valid(iv32), .in_ready(ir32),
        .out_data(od32), .out_valid(ov32), .out_ready(ordy32),
        .done(done32), .busy(busy32), .state_out(st32)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rise8  = 0;
    int rise32 = 0;
    logic pv8  = 1'b0;
    logic pv32 = 1'b0;

    logic [7:0]  q8[$];
    logic [31:0] q32[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record the edge count at which out_valid is first seen high.
    always @(negedge clk) begin
        pv8  <= ov8;
        pv32 <= ov32;
        if (ov8 && !pv8)   rise8  <= cyc;
        if (ov32 && !pv32) rise32 <= cyc;
    end

    // Scoreboards: a beat transfers on the next edge when valid && ready.
    always @(negedge clk) begin
        if (!rst && ov8 && ordy8) begin
            if (q8.size() == 0) chk("d8 unexpected beat", 32'(od8), 32'hDEAD);
            else                chk("d8 beat", 32'(od8), 32'(q8.pop_front()));
        end
        if (!rst && ov32 && ordy32) begin
            if (q32.size() == 0) chk("d32 unexpected beat", od32, ~od32);
            else                 chk("d32 beat", od32, q32.pop_front());
        end
    end

    // Called at posedge+1 in IDLE. Returns at posedge+1 after the last B beat;
    // t0 is the edge count of the start edge.
    task automatic issue8(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int gap, output int t0);
        logic [31:0] word;
        logic        ok;
        int          n;
        start8 = 1'b1;
        op8    = op;
        @(posedge clk); #1;
        t0     = cyc;
        start8 = 1'b0;
        op8    = ~op;
        for (int k = 0; k < 4; k++) q8.push_back(exp[k*8 +: 8]);
        for (int w = 0; w < 2; w++) begin
            word = (w == 0) ? a : b;
            for (int k = 0; k < 4; k++) begin
                if (w == 0) begin
                    for (int g = 0; g < gap; g++) begin
                        iv8 = 1'b0;
                        in8 = 8'hA5;
                        @(posedge clk); #1;
                    end
                end
                iv8 = 1'b1;
                in8 = word[k*8 +: 8];
                n   = 0;
                ok  = 1'b0;
                while (!ok && n < 50) begin
                    @(negedge clk);
                    ok = ir8;
                    @(posedge clk); #1;
                    n++;
                end
                if (!ok) chk("d8 load handshake timeout", 32'(ok), 32'd1);
            end
        end
        iv8 = 1'b0;
    endtask

    task automatic wait_done8(input string name);
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            seen = done8;
            n++;
        end
        chk({name, " done seen"}, 32'(seen), 32'd1);
        chk({name, " idle at done"}, 32'(st8), 32'd0);
        @(negedge clk);
        chk({name, " done one cycle"}, 32'(done8), 32'd0);
        chk({name, " scoreboard drained"}, 32'(q8.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send32(input logic [31:0] data);
        logic ok;
        int   n;
        iv32 = 1'b1;
        in32 = data;
        n    = 0;
        ok   = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = ir32;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) chk("d32 load handshake timeout", 32'(ok), 32'd1);
        iv32 = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          gap;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        int   t0;
        logic seen;
        int   n;

        vt.push_back('{OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 0});
        vt.push_back('{OP_SUB, 32'h40400000, 32'h3F800000, 32'h40000000, 0});
        vt.push_back('{OP_MIN, 32'h00000000, 32'h80000000, 32'h80000000, 0});
        vt.push_back('{OP_MAX, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0});
        vt.push_back('{OP_MIN, 32'h3F800000, 32'hBF800000, 32'hBF800000, 1});
        vt.push_back('{OP_MAX, 32'h3F800000, 32'hBF800000, 32'h3F800000, 0});
        vt.push_back('{OP_MAX, 32'h80000000, 32'h00000000, 32'h00000000, 0});
        vt.push_back('{OP_MIN, 32'hFF800000, 32'hC2C80000, 32'hFF800000, 0});
        vt.push_back('{OP_MAX, 32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 0});
        vt.push_back('{OP_MIN, 32'h3F800000, 32'hFFC00000, 32'h7FC00000, 0});
        vt.push_back('{OP_MIN, 32'hC0000000, 32'hC0400000, 32'hC0400000, 0});
        vt.push_back('{OP_ADD, 32'h3F800000, 32'hBF800000, 32'h00000000, 0});
        vt.push_back('{OP_SUB, 32'h40000000, 32'h40400000, 32'hBF800000, 0});
        vt.push_back('{OP_ADD, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 2});
        vt.push_back('{OP_ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 0});
        vt.push_back('{OP_ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 0});
        vt.push_back('{OP_ADD, 32'h3F800001, 32'h33800000, 32'h3F800002, 0});
        vt.push_back('{OP_SUB, 32'h3F800001, 32'h3F800000, 32'h34000000, 0});
        vt.push_back('{OP_SUB, 32'h00800001, 32'h00800000, 32'h00000001, 0});
        vt.push_back('{OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 0});

        rst = 1'b1;
        start8 = 1'b0; op8 = 2'b00; in8 = '0; iv8 = 1'b0; ordy8 = 1'b1;
        start32 = 1'b0; op32 = 2'b00; in32 = '0; iv32 = 1'b0; ordy32 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset d8 state_out", 32'(st8), 32'd0);
        chk("reset d8 in_ready", 32'(ir8), 32'd0);
        chk("reset d8 out_valid", 32'(ov8), 32'd0);
        chk("reset d8 out_data", 32'(od8), 32'd0);
        chk("reset d8 done/busy", {30'd0, done8, busy8}, 32'd0);
        chk("reset d32 state/valid", {27'd0, st32, ov32, ir32}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency: the start edge ends cycle 0, so the first beat is valid in
        // cycle 2*BEATS+EXEC_LAT+1, i.e. seen 2*BEATS+EXEC_LAT edges later.
        issue8(OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 0, t0);
        wait_done8("lat add");
        chk("d8 first beat latency", 32'(rise8 - t0), 32'd9);

        foreach (vt[i]) begin
            issue8(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].gap, t0);
            wait_done8($sformatf("vec%0d", i));
        end

        // Back-pressure on beat 1, with in_valid gaps while loading A.
        issue8(OP_MIN, 32'h3F8CCCCD, 32'h40490FDB, 32'h3F8CCCCD, 2, t0);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = ov8;
            n++;
        end
        chk("bp out_valid seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        ordy8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp out_valid held", 32'(ov8), 32'd1);
            chk("bp out_data held", 32'(od8), 32'hCC);
        end
        @(posedge clk); #1;
        ordy8 = 1'b1;
        wait_done8("bp");

        // Reset during LOAD_B beat 2 aborts; nothing may be emitted.
        start8 = 1'b1;
        op8    = OP_ADD;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            iv8 = 1'b1;
            in8 = 8'(8'h11 * (k + 1));
            @(posedge clk); #1;
        end
        chk("pre-reset in LOAD_B", 32'(st8), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset state_out", 32'(st8), 32'd0);
        chk("mid reset in_ready", 32'(ir8), 32'd0);
        chk("mid reset out_valid", 32'(ov8), 32'd0);
        chk("mid reset busy", 32'(busy8), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // in_valid alone must not leave IDLE.
        repeat (3) @(posedge clk);
        #1;
        chk("idle ignores in_valid", 32'(st8), 32'd0);
        iv8 = 1'b0;
        issue8(OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 0, t0);
        wait_done8("post reset add");

        // 32-bit instance: start held high throughout; opcode changes after the
        // first start must not affect the first operation.
        op32    = OP_ADD;
        start32 = 1'b1;
        @(posedge clk); #1;
        t0   = cyc;
        op32 = OP_SUB;
        q32.push_back(32'h40400000);
        q32.push_back(32'h40000000);
        send32(32'h3F800000);
        send32(32'h40000000);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            seen = done32;
            n++;
        end
        chk("d32 op1 done seen", 32'(seen), 32'd1);
        chk("d32 first beat latency", 32'(rise32 - t0), 32'd5);
        @(negedge clk);
        chk("d32 back-to-back LOAD_A", 32'(st32), 32'd1);
        chk("d32 done one cycle", 32'(done32), 32'd0);
        @(posedge clk); #1;
        start32 = 1'b0;
        send32(32'h40400000);
        send32(32'h3F800000);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            seen = done32;
            n++;
        end
        chk("d32 op2 done seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("d32 idle after op2", 32'(st32), 32'd0);
        chk("d32 scoreboard drained", 32'(q32.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
